// File: rtl/ctrlport_cmd_master_pkg.sv
// Shared ctrlport constants and the command-master FSM encoding.
package ctrlport_cmd_master_pkg;

  localparam int CTRLPORT_ADDR_W = 20;
  localparam int CTRLPORT_DATA_W = 32;
  localparam int CTRLPORT_STS_W  = 2;

  localparam logic [CTRLPORT_STS_W-1:0] CTRL_STS_OKAY   = 2'd0;
  localparam logic [CTRLPORT_STS_W-1:0] CTRL_STS_CMDERR = 2'd1;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_REQ_ENC  = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC = 2'd2;
  localparam logic [1:0] ST_RESP_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_REQ  = ST_REQ_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_RESP = ST_RESP_ENC
  } state_t;

  // Wait-counter width; a disabled timeout still needs a legal 1-bit vector.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ctrlport_cmd_master.sv
// Single-outstanding ctrlport initiator: command stream in, strobe out, ack or timeout back as a response.
// Strobe 1 cycle after accept; response held until m_resp_ready; no new command until the response is consumed.
module ctrlport_cmd_master
  import ctrlport_cmd_master_pkg::*;
#(
  parameter int                         TIMEOUT      = 1024,
  parameter logic [CTRLPORT_DATA_W-1:0] TIMEOUT_DATA = 32'h0
) (
  input  logic                       ctrlport_clk,
  input  logic                       ctrlport_rst,
  input  logic                       s_cmd_valid,
  output logic                       s_cmd_ready,
  input  logic                       s_cmd_wr,
  input  logic [CTRLPORT_ADDR_W-1:0] s_cmd_addr,
  input  logic [CTRLPORT_DATA_W-1:0] s_cmd_data,
  input  logic [3:0]                 s_cmd_byte_en,
  output logic                       m_ctrlport_req_wr,
  output logic                       m_ctrlport_req_rd,
  output logic [CTRLPORT_ADDR_W-1:0] m_ctrlport_req_addr,
  output logic [CTRLPORT_DATA_W-1:0] m_ctrlport_req_data,
  output logic [3:0]                 m_ctrlport_req_byte_en,
  input  logic                       m_ctrlport_resp_ack,
  input  logic [CTRLPORT_STS_W-1:0]  m_ctrlport_resp_status,
  input  logic [CTRLPORT_DATA_W-1:0] m_ctrlport_resp_data,
  output logic                       m_resp_valid,
  input  logic                       m_resp_ready,
  output logic [CTRLPORT_STS_W-1:0]  m_resp_status,
  output logic [CTRLPORT_DATA_W-1:0] m_resp_data,
  output logic                       m_resp_timeout,
  output logic [15:0]                stat_timeout_count,
  output logic                       stat_stray_ack
);

  localparam int                CNT_W    = wait_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t                       r_state;
  logic [CNT_W-1:0]             r_wait_cnt;
  logic                         r_req_wr;
  logic                         r_req_rd;
  logic [CTRLPORT_ADDR_W-1:0]   r_req_addr;
  logic [CTRLPORT_DATA_W-1:0]   r_req_data;
  logic [3:0]                   r_req_byte_en;
  logic                         r_resp_valid;
  logic [CTRLPORT_STS_W-1:0]    r_resp_status;
  logic [CTRLPORT_DATA_W-1:0]   r_resp_data;
  logic                         r_resp_timeout;
  logic [15:0]                  r_timeout_count;
  logic                         r_stray_ack;

  // Gated by reset so the port reads not-ready during the reset cycle itself.
  assign s_cmd_ready = (r_state == ST_IDLE) && !ctrlport_rst;

  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      r_state         <= ST_IDLE;
      r_wait_cnt      <= '0;
      r_req_wr        <= 1'b0;
      r_req_rd        <= 1'b0;
      r_req_addr      <= '0;
      r_req_data      <= '0;
      r_req_byte_en   <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_status   <= '0;
      r_resp_data     <= '0;
      r_resp_timeout  <= 1'b0;
      r_timeout_count <= '0;
      r_stray_ack     <= 1'b0;
    end else begin
      r_req_wr <= 1'b0;
      r_req_rd <= 1'b0;
      if (m_ctrlport_resp_ack && (r_state != ST_WAIT)) begin
        r_stray_ack <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (s_cmd_valid) begin
            r_req_wr      <= s_cmd_wr;
            r_req_rd      <= !s_cmd_wr;
            r_req_addr    <= s_cmd_addr;
            r_req_data    <= s_cmd_data;
            r_req_byte_en <= s_cmd_byte_en;
            r_state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A real ack always beats a timeout landing in the same cycle.
          if (m_ctrlport_resp_ack) begin
            r_resp_status  <= m_ctrlport_resp_status;
            r_resp_data    <= m_ctrlport_resp_data;
            r_resp_timeout <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_state        <= ST_RESP;
          end else if ((TIMEOUT != 0) && (r_wait_cnt == CNT_LAST)) begin
            r_resp_status  <= CTRL_STS_CMDERR;
            r_resp_data    <= TIMEOUT_DATA;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            if (r_timeout_count != 16'hFFFF) begin
              r_timeout_count <= r_timeout_count + 16'd1;
            end
            r_state        <= ST_RESP;
          end else if (TIMEOUT != 0) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (m_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_ctrlport_req_wr      = r_req_wr;
  assign m_ctrlport_req_rd      = r_req_rd;
  assign m_ctrlport_req_addr    = r_req_addr;
  assign m_ctrlport_req_data    = r_req_data;
  assign m_ctrlport_req_byte_en = r_req_byte_en;
  assign m_resp_valid           = r_resp_valid;
  assign m_resp_status          = r_resp_status;
  assign m_resp_data            = r_resp_data;
  assign m_resp_timeout         = r_resp_timeout;
  assign stat_timeout_count     = r_timeout_count;
  assign stat_stray_ack         = r_stray_ack;

endmodule

// File: tb/tb_ctrlport_cmd_master.sv
// Directed plus randomized bench for ctrlport_cmd_master with a delay-programmable slave.
module tb_ctrlport_cmd_master;

  localparam int          TO      = 16;
  localparam logic [31:0] TO_DATA = 32'hDEAD_0BAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic        s_cmd_wr = 1'b0;
  logic [19:0] s_cmd_addr = '0;
  logic [31:0] s_cmd_data = '0;
  logic [3:0]  s_cmd_byte_en = '0;
  logic        req_wr, req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        ack = 1'b0;
  logic [1:0]  ack_status = '0;
  logic [31:0] ack_data = '0;
  logic        m_resp_valid;
  logic        m_resp_ready = 1'b0;
  logic [1:0]  m_resp_status;
  logic [31:0] m_resp_data;
  logic        m_resp_timeout;
  logic [15:0] stat_timeout_count;
  logic        stat_stray_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int slv_delay = 1;
  logic [1:0]  slv_status = '0;
  logic [31:0] slv_data = '0;
  logic        inj_ack = 1'b0;
  int slv_cd = 0;
  logic slv_fire;
  int strobe_cnt = 0;
  int both_cnt = 0;
  int exp_strobes = 0;
  int exp_tocnt = 0;

  always #5 clk = ~clk;

  ctrlport_cmd_master #(.TIMEOUT(TO), .TIMEOUT_DATA(TO_DATA)) dut (
    .ctrlport_clk(clk), .ctrlport_rst(rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
    .s_cmd_addr(s_cmd_addr), .s_cmd_data(s_cmd_data), .s_cmd_byte_en(s_cmd_byte_en),
    .m_ctrlport_req_wr(req_wr), .m_ctrlport_req_rd(req_rd),
    .m_ctrlport_req_addr(req_addr), .m_ctrlport_req_data(req_data),
    .m_ctrlport_req_byte_en(req_be),
    .m_ctrlport_resp_ack(ack), .m_ctrlport_resp_status(ack_status),
    .m_ctrlport_resp_data(ack_data),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_status(m_resp_status), .m_resp_data(m_resp_data),
    .m_resp_timeout(m_resp_timeout),
    .stat_timeout_count(stat_timeout_count), .stat_stray_ack(stat_stray_ack)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave: acks slv_delay cycles after a strobe (0 = never); main thread may inject stray acks.
  initial forever begin
    @(posedge clk);
    #2;
    slv_fire = 1'b0;
    if (req_wr || req_rd) begin
      strobe_cnt++;
      if (req_wr && req_rd) both_cnt++;
      slv_cd = slv_delay;
    end else if (slv_cd > 0) begin
      slv_cd--;
      slv_fire = (slv_cd == 0);
    end
    ack        = slv_fire || inj_ack;
    ack_status = slv_fire ? slv_status : 2'($urandom_range(0, 3));
    ack_data   = slv_fire ? slv_data : $urandom;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic wr, input logic [19:0] a,
                       input logic [31:0] d, input logic [3:0] be, output int scyc);
    int n;
    n = 0;
    s_cmd_valid = 1'b1; s_cmd_wr = wr; s_cmd_addr = a; s_cmd_data = d; s_cmd_byte_en = be;
    while (!s_cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_cmd_ready_wait"}, (n < 50), 1);
    tick();
    s_cmd_valid = 1'b0;
    s_cmd_wr = 1'($urandom); s_cmd_addr = 20'($urandom); s_cmd_data = $urandom;
    s_cmd_byte_en = 4'($urandom);
    scyc = cyc;
    exp_strobes++;
    chk({tag, "_strobe"}, {req_wr, req_rd}, {wr, !wr});
    chk({tag, "_req_fields"}, {req_addr, req_data, req_be}, {a, d, be});
  endtask

  task automatic finish_cmd(input string tag, input logic [19:0] a, input int dly,
                            input logic [1:0] sts, input logic [31:0] rdat, input int stall);
    int n;
    int lat;
    logic exp_to;
    logic [1:0] es;
    logic [31:0] ed;
    logic stable;
    n = 0;
    exp_to = (dly < 1) || (dly > TO);
    es  = exp_to ? 2'd1 : sts;
    ed  = exp_to ? TO_DATA : rdat;
    lat = exp_to ? TO + 1 : dly + 1;
    if (exp_to && exp_tocnt < 65535) exp_tocnt++;
    while (!m_resp_valid && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_resp"}, {m_resp_status, m_resp_data, m_resp_timeout}, {es, ed, exp_to});
    chk({tag, "_to_count"}, stat_timeout_count, exp_tocnt);
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!m_resp_valid || m_resp_status !== es || m_resp_data !== ed ||
          m_resp_timeout !== exp_to || s_cmd_ready !== 1'b0 || req_addr !== a)
        stable = 1'b0;
    end
    chk({tag, "_stall_stable"}, stable, 1);
    m_resp_ready = 1'b1;
    tick();
    m_resp_ready = 1'b0;
    chk({tag, "_idle_after"}, {m_resp_valid, s_cmd_ready}, 2'b01);
    chk({tag, "_strobe_count"}, strobe_cnt, exp_strobes);
  endtask

  initial begin
    int scyc;
    int dly;
    int stall;
    logic saw;
    logic wr;
    logic [19:0] a;
    logic [31:0] d, rd;
    logic [3:0] be;
    logic [1:0] st;

    // Reset state
    tick();
    tick();
    chk("reset_outputs",
        {s_cmd_ready, req_wr, req_rd, req_addr, req_data, req_be, m_resp_valid,
         m_resp_status, m_resp_data, m_resp_timeout, stat_timeout_count, stat_stray_ack}, '0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", s_cmd_ready, 1);

    // Write, zero-wait ack: 4-cycle accept-to-IDLE
    slv_delay = 1; slv_status = 2'd0; slv_data = 32'h0BAD_F00D;
    issue("wr1", 1'b1, 20'h01004, 32'hA5A5_0001, 4'hF, scyc);
    finish_cmd("wr1", 20'h01004, 1, 2'd0, 32'h0BAD_F00D, 0);
    chk("wr1_period", cyc - (scyc - 1), 4);

    // Read, 7-cycle ack, response stalled 5 cycles
    slv_delay = 7; slv_status = 2'd0; slv_data = 32'h1234_5678;
    issue("rd1", 1'b0, 20'h00C00, 32'h0, 4'hF, scyc);
    finish_cmd("rd1", 20'h00C00, 7, 2'd0, 32'h1234_5678, 5);

    // Timeout, then a late ack is only a stray
    slv_delay = 0;
    issue("to1", 1'b0, 20'h00200, 32'h0, 4'h3, scyc);
    finish_cmd("to1", 20'h00200, 0, 2'd0, 32'h0, 0);
    chk("to1_no_stray_yet", stat_stray_ack, 0);
    tick();
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_resp_valid) saw = 1'b1;
    end
    chk("to1_stray_set", stat_stray_ack, 1);
    chk("to1_no_extra_resp", saw, 0);

    // Ack exactly on the final wait cycle
    slv_delay = TO; slv_status = 2'd2; slv_data = 32'hCAFE_0016;
    issue("edge", 1'b0, 20'h0ABCD, 32'h0, 4'h1, scyc);
    finish_cmd("edge", 20'h0ABCD, TO, 2'd2, 32'hCAFE_0016, 1);

    // Reset during WAIT; the pending ack arrives afterwards
    slv_delay = 6; slv_status = 2'd0; slv_data = 32'h5555_AAAA;
    issue("rst", 1'b1, 20'h00044, 32'h7777_0000, 4'hC, scyc);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_outputs",
        {s_cmd_ready, req_wr, req_rd, req_addr, req_data, req_be, m_resp_valid,
         m_resp_status, m_resp_data, m_resp_timeout, stat_timeout_count, stat_stray_ack}, '0);
    rst = 1'b0;
    exp_tocnt = 0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_resp_valid) saw = 1'b1;
    end
    chk("rst_no_resp", saw, 0);
    chk("rst_stray_after", stat_stray_ack, 1);
    slv_delay = 2; slv_status = 2'd0; slv_data = 32'h0000_0042;
    issue("post_rst", 1'b0, 20'h00048, 32'h0, 4'hF, scyc);
    finish_cmd("post_rst", 20'h00048, 2, 2'd0, 32'h0000_0042, 0);

    // Randomized commands against the reference model
    for (int k = 0; k < 100; k++) begin
      wr = 1'($urandom); a = 20'($urandom); d = $urandom; be = 4'($urandom);
      rd = $urandom; st = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
      stall = int'($urandom_range(0, 3));
      slv_delay = dly; slv_status = st; slv_data = rd;
      issue("rnd", wr, a, d, be, scyc);
      finish_cmd("rnd", a, dly, st, rd, stall);
    end
    chk("total_strobes", strobe_cnt, exp_strobes);
    chk("never_both_strobes", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
